issue_controller: RTL and testbench
===================================

# issue_controller

In-order issue controller for the 3-stage ALU pipeline (decode register, register file/ALU, writeback). It buffers incoming instruction words behind a valid/ready handshake and presents one word per cycle on the pipeline's `instruction` input. The pipeline has no forwarding and the register file has no write-through, so the controller inserts NOP bubbles whenever an instruction would read a register that an in-flight instruction has not yet written back.

## Interface
- `DEPTH`, 4: instruction queue entries; power of two, ≥ 2.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_instr`  in  32  instruction word offered by the fetch side.
- `in_valid`  in  1  `in_instr` is valid.
- `in_ready`  out  1  `!full`; the word is accepted on an edge where `in_valid && in_ready`.
- `instr_out`  out  32  registered word that drives the pipeline's `instruction` input.
- `issued`  out  1  registered; 1 when `instr_out` holds a queued instruction, 0 when it holds a NOP.
- `busy`  out  1  queue non-empty, or either shadow slot holds a valid writer.
- `stall_cnt`  out  16  count of hazard-NOP slots; saturates at 16'hFFFF.
- `issue_cnt`  out  16  count of issued instructions; wraps.

## Operation
- **Field map** (the pipeline decoder uses the same map):
  - `aluop` = [31:29]
  - `data_src` = [28] (1 = immediate)
  - `write_en` = [27]
  - `rd` = [26:22]
  - `rs1` = [21:17]
  - `rs2` = [16:12], meaningful only when `data_src` = 0
  - `imm` = [15:0]
- **NOP** = 32'h0000_0000 (`write_en` = 0).
- **Shadow slots** `sh1`/`sh2`: each holds {valid, rd} for the words in the previous one and two `instr_out` slots. Every cycle, `sh2` ← `sh1`, and `sh1` ← the word just placed on `instr_out`. `valid` is that word's `write_en`; a NOP loads valid = 0.
- **Hazard**: the queue head reads `rs1`, or reads `rs2` when `data_src` = 0, and that register equals the `rd` of a valid `sh1` or `sh2`. Register 0 is not special.
- **States**:
  - IDLE: queue empty; emit NOP.
  - ISSUE: head present and no hazard; pop the head to `instr_out`; `issued` = 1; `issue_cnt`++.
  - STALL: head present and hazard; emit NOP; `issued` = 0; `stall_cnt`++ (saturating); head is retained.
  - State is re-evaluated every cycle from queue occupancy and hazard. The maximum stall is 2 consecutive slots.
- **Queue**: FIFO with a `DEPTH`-entry circular buffer; pointers wrap modulo `DEPTH`; occupancy counter has `log2(DEPTH)+1` bits.
  - Push and pop on the same edge are allowed when neither full nor empty; occupancy is unchanged.
  - Push is refused when full, even if a pop occurs on the same edge.
  - No empty-queue bypass: a word pushed into an empty queue is not issuable in the same cycle.
- **Reset** (synchronous):
  - Clears the queue, both shadows, and both counters.
  - `instr_out` = 0, `issued` = 0, `busy` = 0; `in_ready` = 1 from the first cycle after reset.
  - A word presented during the reset cycle is discarded.
  - Reset mid-stall drops the held head and all queued words.

## Timing
- Word accepted at edge e → earliest `instr_out` at edge e+1 → captured by the pipeline's decode register at edge e+2 → result on the pipeline output at edge e+4.
- Dependency rule: an instruction reading register r appears on `instr_out` at least 3 slots after the slot of the last writer of r (e.g. slot n writer, slot n+3 reader).
- Back-to-back independent instructions issue in consecutive cycles; throughput is 1 per cycle.
- `in_ready` is combinational from registered occupancy only. There is no path from `in_valid` to `in_ready`.

## Structure
- Package `alu4cpu_pkg`:
  - field position constants (`ALUOP_MSB`/`LSB`, `DATA_SRC_BIT`, `WE_BIT`, `RD_`, `RS1_`, `RS2_`, `IMM_` ranges)
  - `NOP_INSTR`
  - state enum {IDLE, ISSUE, STALL}
- One sub-module, `instr_fifo` (parameter `DEPTH`, 32-bit data), with push/pop/full/empty/head. The hazard check, shadow slots and counters stay in `issue_controller`.

## Test plan
- **Reset**: hold `rst` 2 cycles with `in_valid` = 1 → `instr_out` = 0, `issued` = 0, `busy` = 0, counters 0, `in_ready` = 1; the offered word never issues.
- **Independent stream**: push 4 words writing r1, r2, r3, r4 from r10/r11 → `instr_out` shows them on 4 consecutive cycles; `stall_cnt` = 0; `issue_cnt` = 4.
- **RAW distance 1**: write r5, then an R-type reading `rs2` = r5 → exactly 2 NOP slots between them; `stall_cnt` = 2. Repeat with the immediate form (`data_src` = 1) whose `imm` bits [16:12] = 5 → no stall.
- **RAW distance 2**: write r5; independent word; reader of r5 → 1 NOP inserted; `stall_cnt` = 1.
- **Full queue**: `DEPTH` = 4, hold the head stalled, offer 6 words → `in_ready` = 0 after the 4th accept; no word lost or duplicated; issue order equals push order.
- **Reset mid-stall**: assert `rst` while in STALL with 3 words queued → next cycle: queue empty, `instr_out` = NOP, shadows invalid; the following pushed word issues with no stall.

Source files
------------

// File: rtl/alu4cpu_pkg.sv
// Shared definitions for the ALU pipeline issue path: instruction field map,
// the NOP encoding, issue FSM states and the hazard-tracking shadow record.
package alu4cpu_pkg;

  localparam int ALUOP_MSB    = 31;
  localparam int ALUOP_LSB    = 29;
  localparam int DATA_SRC_BIT = 28;
  localparam int WE_BIT       = 27;
  localparam int RD_MSB       = 26;
  localparam int RD_LSB       = 22;
  localparam int RS1_MSB      = 21;
  localparam int RS1_LSB      = 17;
  localparam int RS2_MSB      = 16;
  localparam int RS2_LSB      = 12;
  localparam int IMM_MSB      = 15;
  localparam int IMM_LSB      = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } state_t;

  // Destination of an instruction still in flight; valid only for writers.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } shadow_t;

  function automatic logic shadow_hit(input shadow_t s, input logic [4:0] r);
    return s.valid && (s.rd == r);
  endfunction

endpackage

// File: rtl/issue_controller_if.sv
// Fetch-side instruction handshake. A word transfers on a rising edge where
// in_valid && in_ready; in_ready depends only on registered queue occupancy.
interface issue_controller_if;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_instr, output in_valid, input in_ready);
  modport slave  (input in_instr, input in_valid, output in_ready);
endinterface

// File: rtl/instr_fifo.sv
// Circular-buffer instruction queue; head is the oldest entry, readable
// combinationally. Pushes when full and pops when empty are ignored.
module instr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic        full,
  output logic        empty,
  output logic [31:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/issue_controller.sv
// In-order issue for the 3-stage ALU pipeline: queues fetched words and
// inserts NOPs while the head reads a register an in-flight writer owns.
module issue_controller
  import alu4cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  issue_controller_if.slave   bus,
  output logic [31:0]         instr_out,
  output logic                issued,
  output logic                busy,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         issue_cnt,
  output state_t              state
);
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] head;
  logic        pop;
  logic        hazard;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        uses_rs2;
  shadow_t     sh1;
  shadow_t     sh2;
  state_t      next_state;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (pop),
    .din   (bus.in_instr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign bus.in_ready = !fifo_full;
  assign busy         = !fifo_empty || sh1.valid || sh2.valid;

  assign rs1      = head[RS1_MSB:RS1_LSB];
  assign rs2      = head[RS2_MSB:RS2_LSB];
  assign uses_rs2 = !head[DATA_SRC_BIT];

  // sh1 mirrors the word now on instr_out, sh2 the one before it; a reader
  // clears both only once its writer is three slots behind.
  assign hazard = shadow_hit(sh1, rs1) || shadow_hit(sh2, rs1) ||
                  (uses_rs2 && (shadow_hit(sh1, rs2) || shadow_hit(sh2, rs2)));

  always_comb begin
    next_state = IDLE;
    pop        = 1'b0;
    if (!fifo_empty) begin
      if (hazard) begin
        next_state = STALL;
      end else begin
        next_state = ISSUE;
        pop        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      instr_out <= NOP_INSTR;
      issued    <= 1'b0;
      sh1       <= '0;
      sh2       <= '0;
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      state <= next_state;
      sh2   <= sh1;
      if (next_state == ISSUE) begin
        instr_out <= head;
        issued    <= 1'b1;
        sh1       <= '{valid: head[WE_BIT], rd: head[RD_MSB:RD_LSB]};
        issue_cnt <= issue_cnt + 16'd1;
      end else begin
        instr_out <= NOP_INSTR;
        issued    <= 1'b0;
        sh1       <= '0;
        if (next_state == STALL && stall_cnt != 16'hFFFF) begin
          stall_cnt <= stall_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_controller.sv
// Directed bench for issue_controller: scoreboard of expected issue order,
// NOP-gap tracking per issued word, and counter checks at each idle point.
module tb_issue_controller;
  import alu4cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_out;
  logic        issued;
  logic        busy;
  logic [15:0] stall_cnt;
  logic [15:0] issue_cnt;
  state_t      state;

  issue_controller_if bus ();

  issue_controller #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .instr_out (instr_out),
    .issued    (issued),
    .busy      (busy),
    .stall_cnt (stall_cnt),
    .issue_cnt (issue_cnt),
    .state     (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int          gap_q[$];
  int          nop_run = 0;
  int          bp_cycles = 0;
  int          exp_issue = 0;
  int          exp_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [2:0] op, input logic we,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    logic [31:0] w;
    w        = '0;
    w[31:29] = op;
    w[28]    = 1'b0;
    w[27]    = we;
    w[26:22] = rd;
    w[21:17] = rs1;
    w[16:12] = rs2;
    return w;
  endfunction

  function automatic logic [31:0] mk_i(input logic [2:0] op, input logic we,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [15:0] imm);
    logic [31:0] w;
    w        = '0;
    w[31:29] = op;
    w[28]    = 1'b1;
    w[27]    = we;
    w[26:22] = rd;
    w[21:17] = rs1;
    w[15:0]  = imm;
    return w;
  endfunction

  // ---------------- driver ----------------
  task automatic push_word(input logic [31:0] w);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    while (!bus.in_ready && guard < 50) begin
      bp_cycles++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 50) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: in_ready stuck %b required 1", bus.in_ready);
    end else begin
      exp_q.push_back(w);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    check({name, "_drain"}, {31'd0, busy}, 32'd0);
    check({name, "_pending"}, exp_q.size(), 32'd0);
    check({name, "_issue_cnt"}, {16'd0, issue_cnt}, exp_issue);
    check({name, "_stall_cnt"}, {16'd0, stall_cnt}, exp_stall);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      nop_run = 0;
    end else if (issued) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue: got %h expected no issue", instr_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (instr_out !== e) begin
          fails++;
          $display("FAIL issue_order: got %h expected %h", instr_out, e);
        end
      end
      gap_q.push_back(nop_run);
      nop_run = 0;
    end else begin
      check("nop_slot", instr_out, NOP_INSTR);
      nop_run++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid = 1'b1;
    bus.in_instr = mk_r(3'd2, 1'b1, 5'd9, 5'd1, 5'd2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_instr_out", instr_out, 32'd0);
    check("rst_issued", {31'd0, issued}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_state", {30'd0, state}, {30'd0, IDLE});
    repeat (4) @(negedge clk);
    wait_idle("reset");

    // Independent stream: r1..r4 from r10/r11
    gap_q.delete();
    for (int i = 1; i <= 4; i++) push_word(mk_r(3'd1, 1'b1, 5'(i), 5'd10, 5'd11));
    exp_issue += 4;
    wait_idle("stream");
    check("stream_count", gap_q.size(), 32'd4);
    if (gap_q.size() == 4) begin
      for (int i = 1; i < 4; i++) check("stream_gap", gap_q[i], 32'd0);
    end

    // RAW distance 1, R-type reading rs2
    gap_q.delete();
    push_word(mk_r(3'd1, 1'b1, 5'd5, 5'd10, 5'd11));
    push_word(mk_r(3'd2, 1'b1, 5'd6, 5'd12, 5'd5));
    exp_issue += 2;
    exp_stall += 2;
    wait_idle("raw1");
    check("raw1_count", gap_q.size(), 32'd2);
    if (gap_q.size() == 2) check("raw1_gap", gap_q[1], 32'd2);

    // Immediate form: imm[16:12] happens to equal 5, no dependency
    gap_q.delete();
    push_word(mk_r(3'd1, 1'b1, 5'd5, 5'd10, 5'd11));
    push_word(mk_i(3'd3, 1'b1, 5'd7, 5'd10, 16'h5000));
    exp_issue += 2;
    wait_idle("imm");
    check("imm_count", gap_q.size(), 32'd2);
    if (gap_q.size() == 2) check("imm_gap", gap_q[1], 32'd0);

    // RAW distance 2
    gap_q.delete();
    push_word(mk_r(3'd1, 1'b1, 5'd5, 5'd10, 5'd11));
    push_word(mk_r(3'd1, 1'b1, 5'd8, 5'd12, 5'd13));
    push_word(mk_i(3'd4, 1'b1, 5'd9, 5'd5, 16'h0001));
    exp_issue += 3;
    exp_stall += 1;
    wait_idle("raw2");
    check("raw2_count", gap_q.size(), 32'd3);
    if (gap_q.size() == 3) begin
      check("raw2_gap_mid", gap_q[1], 32'd0);
      check("raw2_gap_reader", gap_q[2], 32'd1);
    end

    // Full queue: dependent chain, each word reads the previous destination
    gap_q.delete();
    bp_cycles = 0;
    push_word(mk_r(3'd1, 1'b1, 5'd1, 5'd10, 5'd11));
    for (int i = 1; i < 8; i++) push_word(mk_r(3'd2, 1'b1, 5'(i + 1), 5'(i), 5'd0));
    exp_issue += 8;
    exp_stall += 14;
    wait_idle("full");
    check("full_backpressure", {31'd0, (bp_cycles > 0)}, 32'd1);
    check("full_count", gap_q.size(), 32'd8);
    if (gap_q.size() == 8) begin
      for (int i = 1; i < 8; i++) check("full_gap", gap_q[i], 32'd2);
    end

    // Reset mid-stall with three words queued
    push_word(mk_r(3'd1, 1'b1, 5'd6, 5'd10, 5'd11));
    push_word(mk_r(3'd2, 1'b1, 5'd20, 5'd6, 5'd11));
    push_word(mk_r(3'd1, 1'b1, 5'd21, 5'd12, 5'd13));
    push_word(mk_r(3'd1, 1'b1, 5'd22, 5'd12, 5'd13));
    check("mid_state", {30'd0, state}, {30'd0, STALL});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_issue = 0;
    exp_stall = 0;
    check("mid_rst_instr_out", instr_out, NOP_INSTR);
    check("mid_rst_issued", {31'd0, issued}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    gap_q.delete();
    push_word(mk_r(3'd2, 1'b1, 5'd23, 5'd6, 5'd6));
    exp_issue += 1;
    wait_idle("post_rst");
    check("post_rst_count", gap_q.size(), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
